puf_sig_collector: RTL and testbench
====================================

PUF_SIG_COLLECTOR -- requirements
Module: puf_sig_collector

Interface
REQ-001 SHALL have parameter PUF_LENGTH, default 8, challenge width; the signature is 2**PUF_LENGTH bits wide (NSIG).
REQ-002 SHALL have parameter SETTLE_CYCLES, default 10, the number of cycles the challenge is held with run low before evaluation (minimum 1).
REQ-003 SHALL have parameter EVAL_CYCLES, default 10, the number of cycles run is held high per challenge (minimum 3, to cover the PUF's output synchronizer).
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  begin a full challenge sweep; sampled in IDLE and DONE only.
REQ-007 abort  input  1  cancel a sweep in progress.
REQ-008 expected  input  NSIG  golden signature for the pass/fail check.
REQ-009 puf_result  input  1  PUF response, already synchronized inside the PUF.
REQ-010 puf_challenge  output  PUF_LENGTH  challenge driven to the PUF.
REQ-011 puf_run  output  1  PUF evaluation enable.
REQ-012 busy  output  1  high while a sweep is in progress.
REQ-013 done  output  1  high while the completed signature is valid.
REQ-014 signature  output  NSIG  collected responses; bit i is the response to challenge i.
REQ-015 pass  output  1  signature == expected, valid while done is high.

Function
REQ-016 SHALL use FSM states IDLE, SETUP, EVAL and DONE; every output SHALL be registered.
REQ-017 IDLE/DONE with start=1 -> SETUP; puf_challenge<=0, signature<=0, done<=0, pass<=0, busy<=1, cycle counter<=0.
REQ-018 SETUP: puf_run=0; after SETTLE_CYCLES cycles in SETUP -> EVAL, counter<=0.
REQ-019 EVAL: puf_run=1; on the edge ending the EVAL_CYCLES-th cycle, SHALL shift in signature<={puf_result, signature[NSIG-1:1]}.
REQ-020 On that edge, if puf_challenge < NSIG-1 -> SETUP with puf_challenge+1; otherwise -> DONE.
REQ-021 Entering DONE SHALL set busy<=0, puf_run<=0 and done<=1, and SHALL set pass<=({puf_result, signature[NSIG-1:1]} == expected).
REQ-022 Per-challenge period SHALL be exactly SETTLE_CYCLES+EVAL_CYCLES cycles; done SHALL rise exactly NSIG*(SETTLE_CYCLES+EVAL_CYCLES) cycles after the edge that sampled start.
REQ-023 puf_challenge SHALL change only on the SETUP entry edge, never while puf_run=1.
REQ-024 start while busy SHALL be ignored; the sweep continues unchanged.
REQ-025 abort in SETUP or EVAL -> IDLE on the next edge; puf_run<=0, busy<=0, done<=0, pass<=0; signature holds its partial value.
REQ-026 abort and start both high in IDLE/DONE: start wins; abort in IDLE/DONE alone has no effect.
REQ-027 DONE SHALL hold signature, done and pass stable until start, abort-free reset, or reset.
REQ-028 The challenge counter SHALL NOT wrap; NSIG-1 is the terminal challenge.

Reset
REQ-029 reset=1 SHALL immediately, without waiting for a clock edge, force state=IDLE, puf_challenge=0, puf_run=0, busy=0, done=0, pass=0, signature=0, counter=0.
REQ-030 reset asserted mid-sweep SHALL discard all progress; after release, a start SHALL begin again from challenge 0.

Verification
REQ-031 PUF model result=1 (defaults), expected=all ones, start 1 cycle -> done at +5120 cycles, signature=all ones, pass=1.
REQ-032 PUF model result=parity(challenge), latched at run rise -> signature[31:0]=0x96696996, bit i=parity(i) for all i; pass=1 with a matching expected, and pass=0 when one bit of expected is flipped.
REQ-033 Timing check -> puf_run low exactly 10 and high exactly 10 cycles per challenge; challenge steps 0..255 by +1 and is stable while run=1.
REQ-034 abort during EVAL of challenge 0x40 -> next edge IDLE, puf_run=0, busy=0, done=0; a following start completes a full sweep correctly.
REQ-035 reset pulse mid-EVAL between clock edges -> outputs reach 0 before the next edge; restart yields the same signature as an uninterrupted run.
REQ-036 start re-pulsed while busy, then again in DONE -> first pulse ignored (done timing unchanged); second clears done/signature and re-sweeps.

Source files
------------

// File: rtl/puf_sig_collector_if.sv
// puf_sig_collector_if
//   Groups the control, golden-signature and PUF-facing signals of the
//   signature collector.
//   master : sweep controller / PUF side (drives start, abort, expected,
//            puf_result; observes challenge, run and results)
//   slave  : the collector itself
`timescale 1ns/1ps
interface puf_sig_collector_if #(
  parameter int PUF_LENGTH = 8
);
  localparam int NSIG = 1 << PUF_LENGTH;

  logic                  start;
  logic                  abort;
  logic [NSIG-1:0]       expected;
  logic                  puf_result;
  logic [PUF_LENGTH-1:0] puf_challenge;
  logic                  puf_run;
  logic                  busy;
  logic                  done;
  logic [NSIG-1:0]       signature;
  logic                  pass;

  modport master (
    output start, abort, expected, puf_result,
    input  puf_challenge, puf_run, busy, done, signature, pass
  );

  modport slave (
    input  start, abort, expected, puf_result,
    output puf_challenge, puf_run, busy, done, signature, pass
  );
endinterface

// File: rtl/puf_sig_collector.sv
// puf_sig_collector
//   Sweeps every PUF challenge 0..NSIG-1, holding each one for SETTLE_CYCLES
//   with puf_run low and then EVAL_CYCLES with puf_run high, and shifts the
//   response sampled at the end of evaluation into the signature (bit i is
//   the response to challenge i). On completion the signature is compared
//   with the golden value.
//   clk   : clock, rising edge
//   reset : asynchronous, active-high
//   bus   : puf_sig_collector_if.slave (start/abort/expected/puf_result in,
//           puf_challenge/puf_run/busy/done/signature/pass out)
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no sweep yet (or aborted); waits for start
//   SETUP | challenge applied, puf_run low, settling
//   EVAL  | puf_run high; response captured on the last cycle
//   DONE  | signature/pass valid and held; start begins a new sweep
`timescale 1ns/1ps
module puf_sig_collector #(
  parameter int PUF_LENGTH    = 8,
  parameter int SETTLE_CYCLES = 10,
  parameter int EVAL_CYCLES   = 10
) (
  input logic                clk,
  input logic                reset,
  puf_sig_collector_if.slave bus
);
  localparam int NSIG = 1 << PUF_LENGTH;
  localparam int CMAX = (SETTLE_CYCLES > EVAL_CYCLES) ? SETTLE_CYCLES : EVAL_CYCLES;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [CW-1:0]         SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0]         EVAL_LAST   = CW'(EVAL_CYCLES - 1);
  localparam logic [PUF_LENGTH-1:0] CHAL_LAST   = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_EVAL,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [PUF_LENGTH-1:0] chal_q, chal_d;
  logic                  run_q, run_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  pass_q, pass_d;
  logic [NSIG-1:0]       sig_q, sig_d;
  logic [NSIG-1:0]       sig_shift;

  assign sig_shift = {bus.puf_result, sig_q[NSIG-1:1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      chal_q  <= '0;
      run_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      sig_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      chal_q  <= chal_d;
      run_q   <= run_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      sig_q   <= sig_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    chal_d  = chal_q;
    run_d   = run_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    sig_d   = sig_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        // start outranks abort here; abort alone is a no-op
        if (bus.start) begin
          state_d = S_SETUP;
          cnt_d   = '0;
          chal_d  = '0;
          run_d   = 1'b0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          sig_d   = '0;
        end
      end

      S_SETUP: begin
        if (bus.abort) begin
          state_d = S_IDLE;
          run_d   = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end else if (cnt_q == SETTLE_LAST) begin
          state_d = S_EVAL;
          cnt_d   = '0;
          run_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_EVAL: begin
        if (bus.abort) begin
          // partial signature is deliberately kept for debug
          state_d = S_IDLE;
          run_d   = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end else if (cnt_q == EVAL_LAST) begin
          sig_d = sig_shift;
          cnt_d = '0;
          run_d = 1'b0;
          if (chal_q == CHAL_LAST) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            // compare against the value being captured on this very edge
            pass_d  = (sig_shift == bus.expected);
          end else begin
            state_d = S_SETUP;
            chal_d  = chal_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.puf_challenge = chal_q;
  assign bus.puf_run       = run_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.pass          = pass_q;
  assign bus.signature     = sig_q;
endmodule

// File: tb/tb_puf_sig_collector.sv
`timescale 1ns/1ps
module tb_puf_sig_collector;
  localparam int PL     = 8;
  localparam int NS     = 1 << PL;
  localparam int SETTLE = 10;
  localparam int EVAL   = 10;
  localparam int SWEEP  = NS * (SETTLE + EVAL);

  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  puf_sig_collector_if #(.PUF_LENGTH(PL)) bus ();

  puf_sig_collector #(
    .PUF_LENGTH(PL),
    .SETTLE_CYCLES(SETTLE),
    .EVAL_CYCLES(EVAL)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PUF model: mode 0 -> constant 1; mode 1 -> parity of the challenge,
  // latched when run rises
  int   mode = 0;
  logic run_prev = 1'b0;
  logic puf_lat = 1'b0;
  always @(posedge clk) begin
    run_prev <= bus.puf_run;
    if (bus.puf_run && !run_prev) puf_lat <= ^bus.puf_challenge;
  end
  assign bus.puf_result = (mode == 0) ? 1'b1 : puf_lat;

  // run/challenge timing monitor, arms itself on the first busy cycle
  logic mon_en = 1'b0;
  logic mon_act = 1'b0;
  logic mon_fin = 1'b0;
  logic mon_prev;
  int   mon_len, mon_bad, mon_rises;
  logic [PL-1:0] mon_exp, mon_hold;
  always @(negedge clk) begin
    if (!mon_en) begin
      mon_act = 1'b0;
      mon_fin = 1'b0;
    end else if (!mon_act && !mon_fin && bus.busy) begin
      mon_act   = 1'b1;
      mon_prev  = 1'b0;
      mon_len   = 0;
      mon_bad   = 0;
      mon_rises = 0;
      mon_exp   = '0;
    end
    if (mon_act) begin
      if (bus.puf_run == mon_prev) begin
        mon_len++;
        if (bus.puf_run && bus.puf_challenge != mon_hold) mon_bad++;
      end else begin
        if (bus.puf_run) begin
          if (mon_len != SETTLE) mon_bad++;
          if (bus.puf_challenge != mon_exp) mon_bad++;
          mon_hold = bus.puf_challenge;
          mon_exp  = mon_exp + 1'b1;
          mon_rises++;
        end else begin
          if (mon_len != EVAL) mon_bad++;
        end
        mon_len = 1;
      end
      mon_prev = bus.puf_run;
      if (bus.done) begin
        mon_act = 1'b0;
        mon_fin = 1'b1;
      end
    end
  end

  task automatic check(input string tag, input logic [NS-1:0] obs, input logic [NS-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NS-1:0] par_sig();
    logic [NS-1:0] r;
    logic [PL-1:0] c;
    for (int i = 0; i < NS; i++) begin
      c    = PL'(i);
      r[i] = ^c;
    end
    return r;
  endfunction

  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!bus.done && n < SWEEP + 1000) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_eval_of(input logic [PL-1:0] ch, output logic found);
    int n;
    n = 0;
    found = 1'b0;
    while (n < SWEEP) begin
      @(negedge clk);
      n++;
      if (bus.puf_run && bus.puf_challenge == ch) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_busy"}, NS'(bus.busy), '0);
    check({tag, "_run"},  NS'(bus.puf_run), '0);
    check({tag, "_done"}, NS'(bus.done), '0);
    check({tag, "_pass"}, NS'(bus.pass), '0);
  endtask

  logic [NS-1:0] par;
  logic [NS-1:0] exp_part;
  logic [NS-1:0] sig_keep;
  logic          found;
  int            n;

  initial begin
    par           = par_sig();
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.expected  = '1;

    repeat (2) @(negedge clk);
    check_cleared("rst");
    check("rst_chal", NS'(bus.puf_challenge), '0);
    check("rst_sig", bus.signature, '0);
    reset = 1'b0;

    // abort alone in IDLE does nothing
    @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    @(negedge clk);
    check_cleared("idle_abort");

    // sweep 1: constant-1 PUF, start and abort together -> start wins
    mode = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("s1_busy", NS'(bus.busy), NS'(1));
    check("s1_run_setup", NS'(bus.puf_run), '0);
    wait_done(n);
    check("s1_latency", NS'(n), NS'(SWEEP));
    check("s1_sig", bus.signature, '1);
    check("s1_pass", NS'(bus.pass), NS'(1));
    check("s1_busy_end", NS'(bus.busy), '0);

    // DONE holds through idle cycles and a lone abort
    repeat (30) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    @(negedge clk);
    check("hold_done", NS'(bus.done), NS'(1));
    check("hold_pass", NS'(bus.pass), NS'(1));
    check("hold_sig", bus.signature, '1);

    // sweep 2: parity PUF with timing monitor
    mode = 1;
    bus.expected = par;
    mon_en = 1'b1;
    pulse_start();
    wait_done(n);
    @(negedge clk);
    mon_en = 1'b0;
    check("s2_latency", NS'(n), NS'(SWEEP));
    check("s2_sig_lo32", NS'(bus.signature[31:0]), NS'(32'h96696996));
    check("s2_sig", bus.signature, par);
    check("s2_pass", NS'(bus.pass), NS'(1));
    check("s2_mon_rises", NS'(mon_rises), NS'(NS));
    check("s2_mon_bad", NS'(mon_bad), '0);

    // sweep 3: one expected bit flipped -> pass low
    bus.expected = par ^ (NS'(1) << 5);
    pulse_start();
    check("s3_done_clr", NS'(bus.done), '0);
    check("s3_sig_clr", bus.signature, '0);
    wait_done(n);
    check("s3_latency", NS'(n), NS'(SWEEP));
    check("s3_sig", bus.signature, par);
    check("s3_pass", NS'(bus.pass), '0);

    // abort during EVAL of challenge 0x40
    bus.expected = par;
    pulse_start();
    wait_eval_of(8'h40, found);
    check("ab_reach", NS'(found), NS'(1));
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check_cleared("ab");
    exp_part = '0;
    exp_part[NS-1:NS-64] = par[63:0];
    check("ab_partial_sig", bus.signature, exp_part);
    repeat (5) @(negedge clk);
    check("ab_stays_idle", NS'(bus.busy), '0);
    pulse_start();
    wait_done(n);
    check("ab_re_latency", NS'(n), NS'(SWEEP));
    check("ab_re_sig", bus.signature, par);
    check("ab_re_pass", NS'(bus.pass), NS'(1));

    // asynchronous reset between edges during EVAL of challenge 0x80
    pulse_start();
    wait_eval_of(8'h80, found);
    check("rs_reach", NS'(found), NS'(1));
    #1 reset = 1'b1;
    #1;
    check_cleared("rs");
    check("rs_chal", NS'(bus.puf_challenge), '0);
    check("rs_sig", bus.signature, '0);
    @(negedge clk);
    reset = 1'b0;
    pulse_start();
    wait_done(n);
    check("rs_re_latency", NS'(n), NS'(SWEEP));
    check("rs_re_sig", bus.signature, par);
    check("rs_re_pass", NS'(bus.pass), NS'(1));

    // start re-pulsed while busy is ignored, then restarts from DONE
    pulse_start();
    repeat (1000) @(negedge clk);
    pulse_start();
    wait_done(n);
    check("rp_latency", NS'(n + 1002), NS'(SWEEP));
    check("rp_sig", bus.signature, par);
    sig_keep = bus.signature;
    check("rp_pass", NS'(bus.pass), NS'(1));
    pulse_start();
    check("rp2_done_clr", NS'(bus.done), '0);
    check("rp2_sig_clr", bus.signature, '0);
    check("rp2_busy", NS'(bus.busy), NS'(1));
    wait_done(n);
    check("rp2_latency", NS'(n), NS'(SWEEP));
    check("rp2_sig", bus.signature, sig_keep);
    check("rp2_pass", NS'(bus.pass), NS'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
